// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment display bus: active-low segment
// codes (CA..CG), BCD code points for blank/invalid, and bus bit positions.
package ssd_pkg;

  localparam logic [6:0] SEG_0     = 7'h01;
  localparam logic [6:0] SEG_1     = 7'h4F;
  localparam logic [6:0] SEG_2     = 7'h12;
  localparam logic [6:0] SEG_3     = 7'h06;
  localparam logic [6:0] SEG_4     = 7'h4C;
  localparam logic [6:0] SEG_5     = 7'h24;
  localparam logic [6:0] SEG_6     = 7'h20;
  localparam logic [6:0] SEG_7     = 7'h0F;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h04;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] BCD_BLANK   = 4'hF;
  localparam logic [3:0] BCD_INVALID = 4'hE;

  localparam int SEG_CA_BIT = 7;
  localparam int SEG_CB_BIT = 6;
  localparam int SEG_CC_BIT = 5;
  localparam int SEG_CD_BIT = 4;
  localparam int SEG_CE_BIT = 3;
  localparam int SEG_CF_BIT = 2;
  localparam int SEG_CG_BIT = 1;
  localparam int SEG_DP_BIT = 0;

  typedef struct packed {
    logic [3:0] bcd;
    logic       dp;
    logic       err;
  } digit_t;

endpackage

// File: rtl/ssd_pattern_decoder.sv
// Combinational inverse of the BCD-to-segment decoder: maps an active-low
// CA..CG pattern back to its BCD digit, flagging blank and unknown patterns.
module ssd_pattern_decoder
  import ssd_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code,
  output logic       is_blank,
  output logic       is_invalid
);

  always_comb begin
    code       = BCD_INVALID;
    is_blank   = 1'b0;
    is_invalid = 1'b0;
    case (seg)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_BLANK: begin
        code     = BCD_BLANK;
        is_blank = 1'b1;
      end
      default:   is_invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/ssd_scan_reader.sv
// Passive readback of a multiplexed seven-segment display: debounces each
// scanned digit, decodes it into a shadow frame and publishes complete frames.
module ssd_scan_reader
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic [7:0]              ssd,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   dp_out,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    frame_valid
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  logic [NUM_DIGITS-1:0] an_meta_reg, an_sync_reg, an_prev_reg;
  logic [7:0]            ssd_meta_reg, ssd_sync_reg, ssd_prev_reg;
  logic [CW-1:0]         stab_cnt_reg;
  logic [NUM_DIGITS-1:0] seen_reg;
  digit_t [NUM_DIGITS-1:0] shadow_reg;

  logic                  changed;
  logic [NUM_DIGITS-1:0] sel;
  logic                  capture;
  logic                  publish;
  logic [3:0]            dec_code;
  logic                  dec_blank;
  logic                  dec_invalid;
  digit_t                capt_digit;

  // Both buses idle high, so all-ones reads as "display off".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_meta_reg  <= '1;
      an_sync_reg  <= '1;
      an_prev_reg  <= '1;
      ssd_meta_reg <= '1;
      ssd_sync_reg <= '1;
      ssd_prev_reg <= '1;
    end else begin
      an_meta_reg  <= an;
      an_sync_reg  <= an_meta_reg;
      an_prev_reg  <= an_sync_reg;
      ssd_meta_reg <= ssd;
      ssd_sync_reg <= ssd_meta_reg;
      ssd_prev_reg <= ssd_sync_reg;
    end
  end

  assign changed = {an_sync_reg, ssd_sync_reg} != {an_prev_reg, ssd_prev_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stab_cnt_reg <= '0;
    end else if (changed) begin
      stab_cnt_reg <= '0;
    end else if (stab_cnt_reg != CW'(STABLE_CYCLES)) begin
      stab_cnt_reg <= stab_cnt_reg + CW'(1);
    end
  end

  // The count only passes through STABLE_CYCLES-1 once per stable pattern,
  // so this single transition is the one-shot capture strobe.
  assign sel     = ~an_sync_reg;
  assign capture = !changed && (stab_cnt_reg == CW'(STABLE_CYCLES - 2)) && $onehot(sel);
  assign publish = &seen_reg;

  ssd_pattern_decoder u_decoder (
    .seg        (ssd_sync_reg[SEG_CA_BIT:SEG_CG_BIT]),
    .code       (dec_code),
    .is_blank   (dec_blank),
    .is_invalid (dec_invalid)
  );

  always_comb begin
    capt_digit.bcd = dec_code;
    capt_digit.dp  = ~ssd_sync_reg[SEG_DP_BIT];
    capt_digit.err = dec_invalid & ~dec_blank;
  end

  // A capture in the publish cycle lands after the seen clear, so it opens
  // the next frame rather than being lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_reg    <= '0;
      frame_valid <= 1'b0;
      bcd_out     <= '1;
      dp_out      <= '0;
      digit_err   <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow_reg[i] <= '{bcd: BCD_BLANK, dp: 1'b0, err: 1'b0};
      end
    end else begin
      frame_valid <= publish;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (publish) begin
          bcd_out[4*i +: 4] <= shadow_reg[i].bcd;
          dp_out[i]         <= shadow_reg[i].dp;
          digit_err[i]      <= shadow_reg[i].err;
          seen_reg[i]       <= 1'b0;
        end
        if (capture && sel[i]) begin
          shadow_reg[i] <= capt_digit;
          seen_reg[i]   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ssd_scan_reader.sv
// Directed bench for ssd_scan_reader: scans hand-picked digit patterns and
// checks published frames, pulse counts and reset behaviour.
module tb_ssd_scan_reader;

  logic        clk;
  logic        rst_n;
  logic [3:0]  an;
  logic [7:0]  ssd;
  logic [15:0] bcd_out;
  logic [3:0]  dp_out;
  logic [3:0]  digit_err;
  logic        frame_valid;

  int checks;
  int errors;
  int frame_cnt;
  int fv_run;
  int fv_max_run;

  ssd_scan_reader #(.NUM_DIGITS(4), .STABLE_CYCLES(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .an          (an),
    .ssd         (ssd),
    .bcd_out     (bcd_out),
    .dp_out      (dp_out),
    .digit_err   (digit_err),
    .frame_valid (frame_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counter and widest high run of frame_valid.
  always @(posedge clk) begin
    if (frame_valid) begin
      frame_cnt = frame_cnt + 1;
      fv_run    = fv_run + 1;
      if (fv_run > fv_max_run) fv_max_run = fv_run;
    end else begin
      fv_run = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n);
    @(negedge clk);
    an  = a;
    ssd = s;
    repeat (n) @(posedge clk);
  endtask

  task automatic scan_digit(input int d, input logic [7:0] s);
    logic [3:0] a;
    a = ~(4'b0001 << d);
    hold(a, s, 12);
    hold(4'hF, 8'hFF, 2);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    an    = 4'hF;
    ssd   = 8'hFF;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    frame_cnt  = 0;
    fv_max_run = 0;
  endtask

  task automatic idle(input int n);
    hold(4'hF, 8'hFF, n);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bcd_out !== 16'hFFFF) begin
      errors++;
      $display("FAIL reset_bcd: got %h expected FFFF", bcd_out);
    end
    checks++;
    if ({dp_out, digit_err, frame_valid} !== 9'b0) begin
      errors++;
      $display("FAIL reset_flags: dp=%b err=%b fv=%b expected all zero", dp_out, digit_err, frame_valid);
    end
    do_reset();
    idle(20);
    checks++;
    if (frame_cnt !== 0) begin
      errors++;
      $display("FAIL reset_idle_frames: got %0d expected 0", frame_cnt);
    end
    $display("test_reset: bcd=%h dp=%b err=%b", bcd_out, dp_out, digit_err);
  endtask

  task automatic test_clean_scan();
    do_reset();
    scan_digit(0, 8'h0D);
    scan_digit(1, 8'h03);
    scan_digit(2, 8'h25);
    scan_digit(3, 8'h9F);
    idle(10);
    checks++;
    if (frame_cnt !== 1) begin
      errors++;
      $display("FAIL clean_frame_count: got %0d expected 1", frame_cnt);
    end
    checks++;
    if (fv_max_run !== 1) begin
      errors++;
      $display("FAIL clean_pulse_width: got %0d expected 1", fv_max_run);
    end
    checks++;
    if (bcd_out !== 16'h1203) begin
      errors++;
      $display("FAIL clean_bcd: got %h expected 1203", bcd_out);
    end
    checks++;
    if (digit_err !== 4'b0000 || dp_out !== 4'b0000) begin
      errors++;
      $display("FAIL clean_flags: err=%b dp=%b expected 0000/0000", digit_err, dp_out);
    end
    $display("test_clean_scan: frames=%0d bcd=%h", frame_cnt, bcd_out);
  endtask

  task automatic test_glitch();
    do_reset();
    hold(4'b1110, 8'h99, 7);
    hold(4'hF, 8'hFF, 2);
    scan_digit(1, 8'h03);
    scan_digit(2, 8'h25);
    scan_digit(3, 8'h9F);
    idle(20);
    checks++;
    if (frame_cnt !== 0) begin
      errors++;
      $display("FAIL glitch_no_frame: got %0d frames expected 0", frame_cnt);
    end
    checks++;
    if (bcd_out !== 16'hFFFF) begin
      errors++;
      $display("FAIL glitch_outputs_held: got %h expected FFFF", bcd_out);
    end
    scan_digit(0, 8'h99);
    idle(6);
    checks++;
    if (frame_cnt !== 1 || bcd_out !== 16'h1204) begin
      errors++;
      $display("FAIL glitch_recover: frames=%0d bcd=%h expected 1/1204", frame_cnt, bcd_out);
    end
    $display("test_glitch: frames=%0d bcd=%h", frame_cnt, bcd_out);
  endtask

  task automatic test_decode_corners();
    do_reset();
    scan_digit(0, 8'h02);
    scan_digit(1, 8'hFF);
    scan_digit(2, 8'h11);
    scan_digit(3, 8'h9F);
    idle(6);
    checks++;
    if (frame_cnt !== 1) begin
      errors++;
      $display("FAIL corner_frame_count: got %0d expected 1", frame_cnt);
    end
    checks++;
    if (bcd_out !== 16'h1EF0) begin
      errors++;
      $display("FAIL corner_bcd: got %h expected 1EF0", bcd_out);
    end
    checks++;
    if (dp_out !== 4'b0001) begin
      errors++;
      $display("FAIL corner_dp: got %b expected 0001", dp_out);
    end
    checks++;
    if (digit_err !== 4'b0100) begin
      errors++;
      $display("FAIL corner_err: got %b expected 0100", digit_err);
    end
    $display("test_decode_corners: bcd=%h dp=%b err=%b", bcd_out, dp_out, digit_err);
  endtask

  task automatic test_ghosting();
    do_reset();
    scan_digit(1, 8'h03);
    scan_digit(2, 8'h25);
    scan_digit(3, 8'h9F);
    hold(4'b1100, 8'h0D, 32);
    idle(6);
    checks++;
    if (frame_cnt !== 0) begin
      errors++;
      $display("FAIL ghost_no_frame: got %0d frames expected 0", frame_cnt);
    end
    checks++;
    if (bcd_out !== 16'hFFFF) begin
      errors++;
      $display("FAIL ghost_outputs_held: got %h expected FFFF", bcd_out);
    end
    $display("test_ghosting: frames=%0d bcd=%h", frame_cnt, bcd_out);
  endtask

  task automatic test_mid_frame_reset();
    do_reset();
    scan_digit(0, 8'h02);
    scan_digit(1, 8'hFF);
    scan_digit(2, 8'h11);
    scan_digit(3, 8'h9F);
    idle(4);
    scan_digit(0, 8'h0D);
    scan_digit(1, 8'h03);
    // Asynchronous assertion away from any clock edge.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bcd_out !== 16'hFFFF || dp_out !== 4'b0 || digit_err !== 4'b0 || frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: bcd=%h dp=%b err=%b fv=%b expected FFFF/0000/0000/0",
               bcd_out, dp_out, digit_err, frame_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    frame_cnt = 0;
    scan_digit(2, 8'h25);
    scan_digit(3, 8'h9F);
    idle(20);
    checks++;
    if (frame_cnt !== 0) begin
      errors++;
      $display("FAIL midreset_partial_dropped: got %0d frames expected 0", frame_cnt);
    end
    scan_digit(0, 8'h0D);
    scan_digit(1, 8'h03);
    idle(6);
    checks++;
    if (frame_cnt !== 1 || bcd_out !== 16'h1203) begin
      errors++;
      $display("FAIL midreset_refill: frames=%0d bcd=%h expected 1/1203", frame_cnt, bcd_out);
    end
    $display("test_mid_frame_reset: frames=%0d bcd=%h", frame_cnt, bcd_out);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    frame_cnt  = 0;
    fv_run     = 0;
    fv_max_run = 0;
    rst_n      = 1'b1;
    an         = 4'hF;
    ssd        = 8'hFF;
    test_reset();
    test_clean_scan();
    test_glitch();
    test_decode_corners();
    test_ghosting();
    test_mid_frame_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ssd_scan_reader.md
# ssd_scan_reader

Passive monitor on the multiplexed seven-segment display bus: samples the active-low anode enables and cathode lines driven to the display and reconstructs the displayed BCD digits. It is the inverse of the BCD-to-segment decoding path and sits beside the display driver as a self-check and readback block for on-board test and verification. Each digit is captured only after its pattern has been stable long enough. Digits are collected into a shadow frame and published coherently once every digit position has been seen.

## Interface
- `NUM_DIGITS`, default 4: number of multiplexed digit positions (anodes).
- `STABLE_CYCLES`, default 8: consecutive identical samples needed before a digit is captured; must be ≥ 2.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `an`  in  NUM_DIGITS: anode enables, active-low; `an[i]=0` selects digit i. Asynchronous to `clk`.
- `ssd`  in  8: cathodes, active-low. Bit 7 is CA, bit 6 CB, bit 5 CC, bit 4 CD, bit 3 CE, bit 2 CF, bit 1 CG, bit 0 DP. Asynchronous to `clk`.
- `bcd_out`  out  4*NUM_DIGITS: digit i is in `[4i+3:4i]`. Value 0–9 for a valid digit, 4'hF for blank, 4'hE for an invalid pattern.
- `dp_out`  out  NUM_DIGITS: decimal point lit for digit i.
- `digit_err`  out  NUM_DIGITS: digit i held an unrecognised segment pattern in the last published frame.
- `frame_valid`  out  1: one-cycle pulse when `bcd_out`, `dp_out` and `digit_err` update.

## Operation
- **Synchronisation:** `an` and `ssd` pass through 2-flop synchronisers, reset to all-ones (display off).
- **Stability tracking:**
  - The block registers the previous synchronised `{an, ssd}`.
  - `stab_cnt`, of width $clog2(STABLE_CYCLES+1), clears to 0 on any change and otherwise increments, saturating at STABLE_CYCLES.
- **Capture:**
  - A capture fires on the single cycle where `stab_cnt` transitions to STABLE_CYCLES-1, meaning the pattern has been identical for STABLE_CYCLES samples.
  - It fires only if exactly one `an` bit is low.
  - No recapture occurs until the pattern changes.
  - Zero or ≥2 low anode bits (blanking interval, ghosting) are ignored.
- **Decode of segments `ssd[7:1]`:**
  - 01→0, 4F→1, 12→2, 06→3, 4C→4, 24→5, 20→6, 0F→7, 00→8, 04→9.
  - 7F→blank, stored as 4'hF with no error.
  - Any other pattern → 4'hE with the error bit set.
  - DP lit when `ssd[0]=0`.
- **Frame assembly:**
  - A capture writes shadow nibble, DP and error for the selected digit and sets `seen[i]`.
  - A repeat capture of the same digit before frame completion overwrites it (latest wins).
  - When `seen` is all ones, the next cycle copies the shadow to the outputs, pulses `frame_valid`, and clears `seen`.
  - A capture in that same cycle is applied after the clear and counts toward the new frame.
- **Reset (including mid-frame):**
  - `bcd_out` = all 4'hF; `dp_out`, `digit_err`, `frame_valid`, `seen`, `stab_cnt` and shadow error/DP = 0.
  - Shadow nibbles = 4'hF; synchronisers = all-ones.
  - Any partial frame is discarded.

## Timing
- Input change to capture: 2 synchroniser cycles + STABLE_CYCLES-1 cycles for the counter.
- Capture of the last missing digit to `frame_valid` high and outputs updated: 1 cycle. Outputs change only in that cycle.
- `frame_valid` is high for exactly 1 cycle per completed frame; there are no back-to-back pulses unless NUM_DIGITS=1.
- A pattern held for STABLE_CYCLES-1 samples is never captured.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `ssd_pkg`:
  - Segment constants SEG_0..SEG_9 and SEG_BLANK (7-bit, active-low CA..CG).
  - BCD_BLANK = 4'hF and BCD_INVALID = 4'hE.
  - Bit-position constants for CA..CG and DP.
- Sub-module `ssd_pattern_decoder`: combinational 7-bit segments → 4-bit code plus `is_blank` and `is_invalid`. It is reused by benches as the reference model.
- Top level holds the synchronisers, stability counter, capture logic, shadow registers and frame logic.

## Test plan
- Reset: assert `rst_n=0` mid-run → `bcd_out=16'hFFFF`, `dp_out=0`, `digit_err=0`, `frame_valid=0`, all immediately (asynchronous).
- Clean scan: each of an=1110/ssd=8'h0D, an=1101/8'h03, an=1011/8'h25, an=0111/8'h9F held for 12 cycles with 2-cycle an=1111 gaps → exactly one `frame_valid` pulse, `bcd_out=16'h1203`, `digit_err=0`.
- Glitch rejection: digit 0 pattern 8'h99 held for 7 samples, then changed → no capture; `seen[0]` stays 0 and no frame completes.
- Decode corners:
  - ssd=8'h02 on digit 0 → nibble 0, `dp_out[0]=1`.
  - ssd=8'hFF on digit 1 → nibble F, no error.
  - ssd=8'h11 on digit 2 → nibble E, `digit_err[2]=1` after the frame.
- Ghosting: an=1100 held for 32 cycles with a valid pattern → no capture, no `frame_valid`.
- Mid-frame reset: capture digits 0 and 1, pulse `rst_n` low, then capture only digits 2 and 3 → no `frame_valid` until digits 0 and 1 are captured again.
